block_assembler: RTL and testbench
==================================

Name: block_assembler

Overview:
- Producer end of the permutation's block handshake: accepts message words, applies Keccak multi-rate padding and packs 576-bit rate blocks.
- Presents each block as block_out/block_ready and holds it until the permutation core returns ack.
- Sits between the host byte stream and the f-permutation core in the low-throughput hash datapath.

Parameters:
- WORD_W, 64, input word width in bits; fixed, must divide RATE_BITS.
- RATE_BITS, 576, block width (rate) in bits.
- WORDS, RATE_BITS/WORD_W (9), words per block.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in  input  WORD_W  message word; message byte 0 in in[63:56].
- in_valid  input  1  in, is_last and byte_num are valid this cycle.
- is_last  input  1  this word is the final message word.
- byte_num  input  3  number of valid bytes in the final word (0..7); ignored unless is_last.
- in_accept  output  1  word is taken on this edge when in_valid && in_accept.
- block_out  output  RATE_BITS  assembled block; word k is block_out[575-64k -: 64].
- block_ready  output  1  block_out is complete and stable.
- ack  input  1  permutation consumed block_out.
- msg_done  output  1  final padded block has been acked.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state=FILL, word counter cnt=0, block_out=0.
  - block_ready=0, msg_done=0, in_accept=1 once reset_n is high.
- FSM states:
  - FILL: in_accept=1. Each accepted non-last word is written to word[cnt], then cnt++.
    - If cnt==WORDS-1 at the write, set block_ready and go to FULL.
  - Accepting a word with is_last=1:
    - Write the padded word: bytes 0..byte_num-1 from in, byte byte_num = 0x01, remaining bytes 0.
    - If cnt==WORDS-1, also OR 0x80 into block_out[7:0], set block_ready and the flag last_blk, and go to FULL.
    - Otherwise go to PAD.
  - PAD: in_accept=0. Write one zero word per cycle at word[cnt], cnt++.
    - The write to word WORDS-1 is 0x80 in its lowest byte; it sets block_ready and last_blk and goes to FULL.
  - FULL: in_accept=0, block_out frozen.
    - On an edge with ack=1: clear block_ready and reset cnt to 0.
    - Go to DONE if last_blk, else FILL. Words are not cleared; each is overwritten before reuse.
  - DONE: msg_done=1, in_accept=0, block_ready=0. Stays until reset.
- Latencies:
  - Last word accepted at word index j (<8): block_ready rises after edge t+(8-j).
  - Non-last 9th word: block_ready rises at its accept edge.
  - After the ack edge, in_accept returns to 1 in the following cycle; no same-cycle refill.
- Pad overlap: when the pad byte lands on byte 71, the final byte is 0x81.
- Message ending on a word boundary: the host sends an extra word with is_last=1, byte_num=0, giving 0x01 followed by zeros.
- Ignored inputs:
  - ack outside FULL.
  - in_valid when in_accept=0.
  - byte_num when is_last=0.
- Reset mid-operation: all state discarded asynchronously; a partial block is lost and block_ready drops immediately.
- Outputs are registered, except in_accept, which is decoded from the state only and never from in_valid.

Optional Feature:
- Macro SHA3_DOMAIN_EN.
  - Defined: first pad byte is 0x06 (SHA-3 domain separation); byte-71 overlap gives 0x86.
  - Undefined: original Keccak padding, 0x01 / 0x81.
- Final 0x80 bit is unaffected either way.

Decomposition:
- Package sha3_pkg holds:
  - RATE_BITS, WORD_W, WORDS.
  - PAD_FIRST (0x01 or 0x06 under the macro), PAD_LAST (0x80).
  - State enum {FILL, PAD, FULL, DONE}.
- One combinational sub-module, pad_word: maps (in, byte_num, is_last, final_word) to the padded 64-bit word.

Test Plan:
- Empty message (in_valid=1, is_last=1, byte_num=0 at cnt 0) -> after 9 edges block_ready=1:
  - word0=0x0100000000000000, words1..7=0, word8=0x0000000000000080.
  - ack -> msg_done=1 next cycle.
- 9 full words 0x1111…*k, then last word byte_num=3 value 0xAABBCCxxxxxxxxxx:
  - Block 1 = the 9 words, ready at the 9th accept.
  - After ack, block 2 word0=0xAABBCC0100000000 and word8 ends 0x80.
- Last word at cnt=8 with byte_num=7 -> block_ready at the accept edge, block_out[7:0]=0x81 (0x86 with SHA3_DOMAIN_EN).
- Hold ack=0 for 30 cycles with block_ready=1 and in_valid toggling:
  - block_out unchanged, in_accept=0, no words consumed.
  - Single-cycle ack -> block_ready=0 next cycle.
- ack pulsed in FILL and PAD -> no effect on cnt, block_ready or msg_done.
- reset_n asserted mid-PAD (cnt=4) -> block_ready=0, msg_done=0 immediately; a following empty message yields the same block as the first scenario.

Source files
------------

// File: rtl/sha3_pkg.sv
// Shared widths, pad constants and FSM encoding for the rate-block assembler.
// Define SHA3_DOMAIN_EN to use SHA-3 domain separation (first pad byte 0x06).
package sha3_pkg;

    localparam int unsigned RATE_BITS = 576;
    localparam int unsigned WORD_W    = 64;
    localparam int unsigned WORDS     = RATE_BITS / WORD_W;
    localparam int unsigned BYTES     = WORD_W / 8;
    localparam int unsigned CNT_W     = 4;

`ifdef SHA3_DOMAIN_EN
    localparam logic [7:0] PAD_FIRST = 8'h06;
`else
    localparam logic [7:0] PAD_FIRST = 8'h01;
`endif
    localparam logic [7:0] PAD_LAST  = 8'h80;

    typedef enum logic [1:0] {
        FILL,
        PAD,
        FULL,
        DONE
    } state_t;

endpackage

// File: rtl/block_assembler_pad_word.sv
// Combinational padding of one message word: keeps the valid bytes of a final
// word, inserts the first pad byte, and ORs the closing 0x80 into the last word.
module pad_word
    import sha3_pkg::*;
(
    input  logic [WORD_W-1:0] in,
    input  logic [2:0]        byte_num,
    input  logic              is_last,
    input  logic              final_word,
    output logic [WORD_W-1:0] word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < int'(BYTES); i++) begin
            if (!is_last || (3'(i) < byte_num)) begin
                word[WORD_W-1-8*i -: 8] = in[WORD_W-1-8*i -: 8];
            end else if (3'(i) == byte_num) begin
                word[WORD_W-1-8*i -: 8] = PAD_FIRST;
            end
        end
        if (final_word) begin
            word[7:0] = word[7:0] | PAD_LAST;
        end
    end

endmodule

// File: rtl/block_assembler.sv
// Packs message words into padded 576-bit rate blocks and holds each block
// until the permutation acks it. Pad byte selected by SHA3_DOMAIN_EN.
module block_assembler
    import sha3_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_W-1:0]    in,
    input  logic                 in_valid,
    input  logic                 is_last,
    input  logic [2:0]           byte_num,
    output logic                 in_accept,
    output logic [RATE_BITS-1:0] block_out,
    output logic                 block_ready,
    input  logic                 ack,
    output logic                 msg_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WORDS - 1);

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [RATE_BITS-1:0] block_n;
    logic                 ready_n, done_n, last_blk, last_n;
    logic                 we;
    logic [WORD_W-1:0]    pw_in, pw_word;
    logic                 pw_last, pw_final;

    // Decoded from state only, so the host sees it independent of in_valid.
    assign in_accept = (state == FILL);

    pad_word u_pad_word (
        .in         (pw_in),
        .byte_num   (byte_num),
        .is_last    (pw_last),
        .final_word (pw_final),
        .word       (pw_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FILL;
            cnt         <= '0;
            block_out   <= '0;
            block_ready <= 1'b0;
            msg_done    <= 1'b0;
            last_blk    <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            block_out   <= block_n;
            block_ready <= ready_n;
            msg_done    <= done_n;
            last_blk    <= last_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        block_n  = block_out;
        ready_n  = block_ready;
        done_n   = msg_done;
        last_n   = last_blk;
        we       = 1'b0;
        pw_in    = in;
        pw_last  = is_last;
        pw_final = 1'b0;

        case (state)
            FILL: begin
                if (in_valid) begin
                    we       = 1'b1;
                    pw_final = is_last && (cnt == LAST_IDX);
                    if (cnt == LAST_IDX) begin
                        ready_n = 1'b1;
                        last_n  = is_last;
                        state_n = FULL;
                    end else begin
                        cnt_n   = cnt + CNT_W'(1);
                        state_n = is_last ? PAD : FILL;
                    end
                end
            end
            PAD: begin
                we       = 1'b1;
                pw_in    = '0;
                pw_last  = 1'b0;
                pw_final = (cnt == LAST_IDX);
                if (cnt == LAST_IDX) begin
                    ready_n = 1'b1;
                    last_n  = 1'b1;
                    state_n = FULL;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            FULL: begin
                if (ack) begin
                    ready_n = 1'b0;
                    cnt_n   = '0;
                    done_n  = last_blk;
                    state_n = last_blk ? DONE : FILL;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                ready_n = 1'b0;
            end
            default: state_n = FILL;
        endcase

        // Word slot cnt is overwritten; stale words from a prior block never survive.
        if (we) begin
            for (int k = 0; k < int'(WORDS); k++) begin
                if (cnt == CNT_W'(k)) begin
                    block_n[RATE_BITS-1-WORD_W*k -: WORD_W] = pw_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_block_assembler.sv
// Directed bench for block_assembler: padding, latency, ack handshake and reset.
module tb_block_assembler;
    import sha3_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [63:0]          in;
    logic                 in_valid;
    logic                 is_last;
    logic [2:0]           byte_num;
    logic                 in_accept;
    logic [RATE_BITS-1:0] block_out;
    logic                 block_ready;
    logic                 ack;
    logic                 msg_done;

    int total = 0;
    int bad   = 0;

`ifdef SHA3_DOMAIN_EN
    localparam logic [7:0] PF = 8'h06;
`else
    localparam logic [7:0] PF = 8'h01;
`endif
    localparam logic [575:0] EMPTY_BLK = {PF, 56'h0, 448'h0, 64'h80};

    block_assembler dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in          (in),
        .in_valid    (in_valid),
        .is_last     (is_last),
        .byte_num    (byte_num),
        .in_accept   (in_accept),
        .block_out   (block_out),
        .block_ready (block_ready),
        .ack         (ack),
        .msg_done    (msg_done)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        in_valid = 1'b0;
        is_last  = 1'b0;
        byte_num = 3'd0;
        in       = 64'h0;
        ack      = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        reset_n = 1'b0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!block_ready && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset;
        idle();
        reset_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (block_ready !== 1'b0 || msg_done !== 1'b0 || block_out !== '0) begin
            bad++;
            $display("FAIL reset_outputs: ready=%b done=%b blk_nonzero=%b, want 0 0 0",
                     block_ready, msg_done, |block_out);
        end
        repeat (2) step();
        reset_n = 1'b1;
        step();
        total++;
        if (in_accept !== 1'b1 || block_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: accept=%b ready=%b, want 1 0", in_accept, block_ready);
        end
    endtask

    task automatic test_empty;
        int n;
        do_reset();
        in = 64'hDEADBEEFCAFEF00D; in_valid = 1'b1; is_last = 1'b1; byte_num = 3'd0;
        step();
        idle();
        total++;
        if (in_accept !== 1'b0) begin
            bad++;
            $display("FAIL empty_pad_accept: got %b want 0", in_accept);
        end
        wait_ready(n);
        n++;
        total++;
        if (n != 9) begin
            bad++;
            $display("FAIL empty_latency: got %0d edges want 9", n);
        end
        total++;
        if (block_out !== EMPTY_BLK) begin
            bad++;
            $display("FAIL empty_block: got %h want %h", block_out, EMPTY_BLK);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++;
        if (block_ready !== 1'b0 || msg_done !== 1'b1 || in_accept !== 1'b0) begin
            bad++;
            $display("FAIL empty_ack: ready=%b done=%b accept=%b, want 0 1 0",
                     block_ready, msg_done, in_accept);
        end
        in_valid = 1'b1;
        step();
        idle();
        total++;
        if (msg_done !== 1'b1 || block_ready !== 1'b0) begin
            bad++;
            $display("FAIL done_sticky: done=%b ready=%b, want 1 0", msg_done, block_ready);
        end
    endtask

    task automatic test_two_blocks;
        logic [575:0] exp;
        logic [575:0] exp2;
        int n;
        do_reset();
        exp = '0;
        for (int k = 1; k <= 9; k++) begin
            in = 64'h1111111111111111 * 64'(k);
            exp[575-64*(k-1) -: 64] = in;
            in_valid = 1'b1;
            is_last  = 1'b0;
            byte_num = 3'd5;
            step();
            if (k == 8) begin
                total++;
                if (block_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL two_early_ready: got %b want 0", block_ready);
                end
            end
        end
        total++;
        if (block_ready !== 1'b1 || block_out !== exp) begin
            bad++;
            $display("FAIL two_block1: ready=%b got %h want %h", block_ready, block_out, exp);
        end
        for (int i = 0; i < 30; i++) begin
            in_valid = i[0];
            is_last  = 1'b0;
            in       = {$urandom, $urandom};
            step();
            total++;
            if (block_out !== exp || in_accept !== 1'b0 || block_ready !== 1'b1) begin
                bad++;
                $display("FAIL hold_cycle%0d: accept=%b ready=%b blk_changed=%b, want 0 1 0",
                         i, in_accept, block_ready, block_out !== exp);
            end
        end
        idle();
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++;
        if (block_ready !== 1'b0 || in_accept !== 1'b1 || msg_done !== 1'b0) begin
            bad++;
            $display("FAIL two_ack1: ready=%b accept=%b done=%b, want 0 1 0",
                     block_ready, in_accept, msg_done);
        end
        in = 64'hAABBCCDDEEFF0011; in_valid = 1'b1; is_last = 1'b1; byte_num = 3'd3;
        step();
        idle();
        wait_ready(n);
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL two_latency: got %0d want 8", n);
        end
        exp2 = {24'hAABBCC, PF, 32'h0, 448'h0, 64'h80};
        total++;
        if (block_out !== exp2) begin
            bad++;
            $display("FAIL two_block2: got %h want %h", block_out, exp2);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++;
        if (msg_done !== 1'b1) begin
            bad++;
            $display("FAIL two_done: got %b want 1", msg_done);
        end
    endtask

    task automatic test_overlap;
        logic [7:0] tail;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            in = 64'h0101010101010101 * 64'(k + 1);
            in_valid = 1'b1;
            is_last  = 1'b0;
            step();
        end
        in = 64'h0102030405060708; is_last = 1'b1; byte_num = 3'd7;
        step();
        idle();
        tail = PF | 8'h80;
        total++;
        if (block_ready !== 1'b1) begin
            bad++;
            $display("FAIL overlap_ready: got %b want 1", block_ready);
        end
        total++;
        if (block_out[63:0] !== {56'h01020304050607, tail}) begin
            bad++;
            $display("FAIL overlap_word8: got %h want %h", block_out[63:0],
                     {56'h01020304050607, tail});
        end
        total++;
        if (block_out[575:512] !== 64'h0101010101010101) begin
            bad++;
            $display("FAIL overlap_word0: got %h want 0101010101010101", block_out[575:512]);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++;
        if (msg_done !== 1'b1 || block_ready !== 1'b0) begin
            bad++;
            $display("FAIL overlap_done: done=%b ready=%b, want 1 0", msg_done, block_ready);
        end
    endtask

    task automatic test_ack_ignored;
        logic [575:0] exp;
        int n;
        do_reset();
        ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in = 64'hA0A0A0A0A0A0A0A0 + 64'(k);
            in_valid = 1'b1;
            is_last  = 1'b0;
            step();
        end
        total++;
        if (block_ready !== 1'b0 || msg_done !== 1'b0 || in_accept !== 1'b1) begin
            bad++;
            $display("FAIL ack_fill: ready=%b done=%b accept=%b, want 0 0 1",
                     block_ready, msg_done, in_accept);
        end
        in = 64'h1234567890ABCDEF; is_last = 1'b1; byte_num = 3'd2;
        step();
        in_valid = 1'b0; is_last = 1'b0;
        wait_ready(n);
        ack = 1'b0;
        total++;
        if (n != 5 || msg_done !== 1'b0) begin
            bad++;
            $display("FAIL ack_pad: latency=%0d done=%b, want 5 0", n, msg_done);
        end
        exp = {64'hA0A0A0A0A0A0A0A0, 64'hA0A0A0A0A0A0A0A1, 64'hA0A0A0A0A0A0A0A2,
               16'h1234, PF, 40'h0, 256'h0, 64'h80};
        total++;
        if (block_out !== exp) begin
            bad++;
            $display("FAIL ack_block: got %h want %h", block_out, exp);
        end
        step();
        total++;
        if (block_ready !== 1'b1 || msg_done !== 1'b0) begin
            bad++;
            $display("FAIL ack_hold: ready=%b done=%b, want 1 0", block_ready, msg_done);
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        total++;
        if (msg_done !== 1'b1) begin
            bad++;
            $display("FAIL ack_done: got %b want 1", msg_done);
        end
    endtask

    task automatic test_reset_mid_pad;
        int n;
        do_reset();
        in = 64'hFFFFFFFFFFFFFFFF; in_valid = 1'b1; is_last = 1'b1; byte_num = 3'd0;
        step();
        idle();
        repeat (3) step();
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (block_ready !== 1'b0 || msg_done !== 1'b0 || block_out !== '0) begin
            bad++;
            $display("FAIL midpad_reset: ready=%b done=%b blk_nonzero=%b, want 0 0 0",
                     block_ready, msg_done, |block_out);
        end
        step();
        reset_n = 1'b1;
        step();
        total++;
        if (in_accept !== 1'b1) begin
            bad++;
            $display("FAIL midpad_accept: got %b want 1", in_accept);
        end
        in = 64'h5555555555555555; in_valid = 1'b1; is_last = 1'b1; byte_num = 3'd0;
        step();
        idle();
        wait_ready(n);
        total++;
        if (n != 8 || block_out !== EMPTY_BLK) begin
            bad++;
            $display("FAIL midpad_rerun: latency=%0d got %h want 8 %h", n, block_out, EMPTY_BLK);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (block_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_reset_ready: got %b want 0", block_ready);
        end
        step();
        reset_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_empty();
        test_two_blocks();
        test_overlap();
        test_ack_ignored();
        test_reset_mid_pad();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
